data_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the CPU's load/store path and a multi-cycle backing data memory. Accepts one word-aligned load or store at a time over a valid/ready handshake, answers hits in one cycle, and on a miss writes back a dirty victim block and then refills. It also keeps hit and miss counters that the bench reads at halt.

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_line_array.sv | 52 +++++
 rtl/data_cache.sv | 96 +++++++++
 tb/tb_data_cache.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: state encoding and address-split helpers shared by the data cache
package cache_pkg;
    localparam int WORD_W          = 32;
    localparam int DEF_LINE_COUNT  = 16;
    localparam int DEF_BLOCK_WORDS = 4;
    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;
    function automatic int offset_w(int block_words);
        return $clog2(block_words) + 2;
    endfunction
    function automatic int index_w(int line_count);
        return $clog2(line_count);
    endfunction
    function automatic int tag_w(int line_count, int block_words);
        return 32 - index_w(line_count) - offset_w(block_words);
    endfunction
    function automatic int block_w(int block_words);
        return block_words * WORD_W;
    endfunction
endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: per-line valid/dirty/tag/data storage with combinational read
module cache_line_array import cache_pkg::*; #(
    parameter int LINE_COUNT  = DEF_LINE_COUNT,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    localparam int IW  = index_w(LINE_COUNT),
    localparam int TW  = tag_w(LINE_COUNT, BLOCK_WORDS),
    localparam int BW  = block_w(BLOCK_WORDS),
    localparam int WSW = $clog2(BLOCK_WORDS)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IW-1:0]  index,
    output logic           rd_valid,
    output logic           rd_dirty,
    output logic [TW-1:0]  rd_tag,
    output logic [BW-1:0]  rd_block,
    input  logic           block_we,
    input  logic [TW-1:0]  block_tag,
    input  logic [BW-1:0]  block_data,
    input  logic           word_we,
    input  logic [WSW-1:0] word_sel,
    input  logic [31:0]    word_data
);
    logic [LINE_COUNT-1:0] valid, dirty;
    logic [TW-1:0] tags [LINE_COUNT];
    logic [BW-1:0] data [LINE_COUNT];
    assign rd_valid = valid[index];
    assign rd_dirty = dirty[index];
    assign rd_tag   = tags[index];
    assign rd_block = data[index];
    // flags are the only reset state: a refill makes a line clean, a word store dirties it
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (block_we) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (word_we) begin
            dirty[index] <= 1'b1;
        end
    end
    // contents: whole-block refill with new tag, or single-word store
    always_ff @(posedge clk) begin
        if (block_we) begin
            tags[index] <= block_tag;
            data[index] <= block_data;
        end else if (word_we) begin
            data[index][word_sel*WORD_W +: WORD_W] <= word_data;
        end
    end
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back write-allocate cache with hit/miss counters
module data_cache import cache_pkg::*; #(
    parameter int LINE_COUNT  = DEF_LINE_COUNT,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    localparam int OW = offset_w(BLOCK_WORDS),
    localparam int IW = index_w(LINE_COUNT),
    localparam int TW = tag_w(LINE_COUNT, BLOCK_WORDS),
    localparam int BW = block_w(BLOCK_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          is_input_valid,
    input  logic [31:0]   addr,
    input  logic          mem_rw,
    input  logic [31:0]   din,
    output logic          is_ready,
    output logic          is_output_valid,
    output logic [31:0]   dout,
    output logic          is_hit,
    output logic          mem_req,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [BW-1:0] mem_wdata,
    input  logic [BW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
);
    state_t state, state_next;
    logic [31:2] req_addr;
    logic [31:0] req_din;
    logic req_rw, missed;
    logic line_valid, line_dirty, hit, miss;
    logic [TW-1:0] line_tag;
    logic [BW-1:0] line_block;
    logic unused_byte_offset;
    wire [IW-1:0]   index    = req_addr[OW +: IW];
    wire [TW-1:0]   tag      = req_addr[31 -: TW];
    wire [OW-3:0]   word_sel = req_addr[OW-1:2];
    assign unused_byte_offset = ^addr[1:0];
    cache_line_array #(.LINE_COUNT(LINE_COUNT), .BLOCK_WORDS(BLOCK_WORDS)) lines (
        .clk(clk), .reset(reset), .index(index),
        .rd_valid(line_valid), .rd_dirty(line_dirty), .rd_tag(line_tag), .rd_block(line_block),
        .block_we(state == ALLOCATE && mem_ack), .block_tag(tag), .block_data(mem_rdata),
        .word_we(hit && req_rw), .word_sel(word_sel), .word_data(req_din)
    );
    assign hit             = state == COMPARE && line_valid && line_tag == tag;
    assign miss            = state == COMPARE && !hit;
    assign is_ready        = state == IDLE;
    assign is_output_valid = hit;
    assign is_hit          = hit && !missed;
    assign dout            = (hit && !req_rw) ? line_block[word_sel*WORD_W +: WORD_W] : '0;
    assign mem_req         = state == WRITEBACK || state == ALLOCATE;
    assign mem_we          = state == WRITEBACK;
    assign mem_addr        = state == WRITEBACK ? {line_tag, index, {OW{1'b0}}} :
                             state == ALLOCATE  ? {tag, index, {OW{1'b0}}} : '0;
    assign mem_wdata       = state == WRITEBACK ? line_block : '0;
    // state register, request latch, and a marker that this request already missed once
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            missed <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && is_input_valid) begin
                req_addr <= addr[31:2];
                req_rw   <= mem_rw;
                req_din  <= din;
                missed   <= 1'b0;
            end else if (miss) begin
                missed <= 1'b1;
            end
        end
    end
    // next state: dirty victims are written back before the refill read
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = is_input_valid ? COMPARE : IDLE;
            COMPARE:   state_next = hit ? IDLE : (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
            WRITEBACK: state_next = mem_ack ? ALLOCATE : WRITEBACK;
            ALLOCATE:  state_next = mem_ack ? COMPARE : ALLOCATE;
            default:   state_next = IDLE;
        endcase
    end
    // saturating counters; the post-refill lookup of a missed request is not a hit
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (is_hit && hit_count != '1) hit_count <= hit_count + 32'd1;
            if (miss && miss_count != '1) miss_count <= miss_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed scoreboard bench for data_cache with a behavioural backing memory
module tb_data_cache;
    localparam int BW = 128;
    logic clk = 0, reset = 1, is_input_valid = 0, mem_rw = 0, mem_ack = 0;
    logic [31:0] addr = 0, din = 0;
    logic [BW-1:0] mem_rdata = '0;
    logic is_ready, is_output_valid, is_hit, mem_req, mem_we;
    logic [31:0] dout, mem_addr, hit_count, miss_count;
    logic [BW-1:0] mem_wdata;

    typedef struct {logic we; logic [31:0] addr; logic [BW-1:0] wdata;} txn_t;
    typedef struct {logic [31:0] dout; logic hit; logic is_load;} exp_t;
    exp_t sb[$];
    exp_t mon_e;
    txn_t log_q[$];
    txn_t cap;
    logic [31:0] mem_w[int unsigned];
    logic [31:0] ref_w[int unsigned];
    int tests = 0, fails = 0, out_count = 0, out_before = 0, lat = 0;
    int unstable = 0, ready_viol = 0, delay = 3, ack_req = 0, acks_done = 0, cnt = 0;
    bit auto_mem = 1;

    always #5 clk = ~clk;

    data_cache dut (
        .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr), .mem_rw(mem_rw),
        .din(din), .is_ready(is_ready), .is_output_valid(is_output_valid), .dout(dout),
        .is_hit(is_hit), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    function automatic logic [31:0] dflt(logic [31:0] a);
        return 32'hA000_0000 ^ a;
    endfunction
    function automatic logic [31:0] mem_rd(logic [31:0] a);
        return mem_w.exists(a) ? mem_w[a] : dflt(a);
    endfunction
    function automatic logic [31:0] ref_rd(logic [31:0] a);
        return ref_w.exists(a) ? ref_w[a] : dflt(a);
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // output monitor: pops the scoreboard on every completion
    always @(negedge clk) begin
        if (mem_req && is_ready) ready_viol++;
        if (is_output_valid) begin
            out_count++;
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL sb_unexpected: observed output dout=%0h expected none", dout);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("is_hit", is_hit, mon_e.hit);
                if (mon_e.is_load) chk("load_dout", dout, mon_e.dout);
            end
        end
    end

    // backing memory: acks after `delay` request cycles, tracks request stability
    initial begin
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 0;
                cnt = 0;
            end else if (ack_req != acks_done) begin
                acks_done++;
                mem_ack = 1;
            end else if (auto_mem && mem_req) begin
                if (cnt == 0) cap = '{mem_we, mem_addr, mem_wdata};
                else if (cap.we !== mem_we || cap.addr !== mem_addr || cap.wdata !== mem_wdata) unstable++;
                cnt++;
                if (cnt >= delay) begin
                    mem_ack = 1;
                    log_q.push_back(cap);
                    for (int i = 0; i < 4; i++) begin
                        if (mem_we) mem_w[mem_addr + 4*i] = mem_wdata[i*32 +: 32];
                        else mem_rdata[i*32 +: 32] = mem_rd(mem_addr + 4*i);
                    end
                end
            end else begin
                if (cnt != 0) unstable++;
                cnt = 0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(logic rw, logic [31:0] a, logic [31:0] d, logic exp_hit);
        int n = 0;
        while (!is_ready && n < 200) begin step(); n++; end
        chk("ready_wait", is_ready, 1);
        is_input_valid = 1; mem_rw = rw; addr = a; din = d;
        sb.push_back('{ref_rd(a), exp_hit, !rw});
        if (rw) ref_w[a] = d;
        out_before = out_count;
        step();
        is_input_valid = 0;
        lat = 1;
    endtask

    task automatic wait_done();
        while (out_count == out_before && lat < 200) begin step(); lat++; end
        chk("completion", out_count, out_before + 1);
    endtask

    task automatic access(logic rw, logic [31:0] a, logic [31:0] d, logic exp_hit);
        issue(rw, a, d, exp_hit);
        wait_done();
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 50) begin step(); n++; end
        chk("mem_req_seen", mem_req, 1);
    endtask

    initial begin
        mem_w[32'h100] = 32'h11; mem_w[32'h104] = 32'h22; mem_w[32'h108] = 32'h33; mem_w[32'h10C] = 32'h44;
        ref_w[32'h100] = 32'h11; ref_w[32'h104] = 32'h22; ref_w[32'h108] = 32'h33; ref_w[32'h10C] = 32'h44;
        step(); step();
        chk("rst_ready", is_ready, 1);
        chk("rst_ovalid", is_output_valid, 0);
        chk("rst_hit", is_hit, 0);
        chk("rst_dout", dout, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        reset = 0;
        step();
        // cold miss then hit
        access(0, 32'h100, 0, 0);
        access(0, 32'h104, 0, 1);
        chk("hit_latency", lat, 1);
        step();
        chk("cnt_hit_1", hit_count, 1);
        chk("cnt_miss_1", miss_count, 1);
        // store hit then dirty eviction
        access(1, 32'h100, 32'hDEADBEEF, 1);
        log_q.delete();
        access(0, 32'h200, 0, 0);
        chk("evict_txns", log_q.size(), 2);
        chk("wb_we", log_q[0].we, 1);
        chk("wb_addr", log_q[0].addr, 32'h100);
        chk("wb_word0", log_q[0].wdata[31:0], 32'hDEADBEEF);
        chk("refill_we", log_q[1].we, 0);
        chk("refill_addr", log_q[1].addr, 32'h200);
        // clean eviction
        log_q.delete();
        access(0, 32'h300, 0, 0);
        chk("clean_we", log_q[0].we, 0);
        chk("clean_addr", log_q[0].addr, 32'h300);
        // slow memory: stability, ready held low, stray request ignored
        access(1, 32'h304, 32'hCAFEF00D, 1);
        log_q.delete();
        unstable = 0;
        delay = 10;
        issue(0, 32'h400, 0, 0);
        wait_req();
        is_input_valid = 1; addr = 32'h500; mem_rw = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stray_not_ready", is_ready, 0);
        end
        is_input_valid = 0;
        wait_done();
        repeat (5) step();
        chk("stray_no_output", out_count, out_before + 1);
        chk("slow_txns", log_q.size(), 2);
        chk("slow_wb_addr", log_q[0].addr, 32'h300);
        chk("slow_wb_word0", log_q[0].wdata[31:0], 32'hA000_0300);
        chk("slow_wb_word1", log_q[0].wdata[63:32], 32'hCAFEF00D);
        chk("slow_refill_addr", log_q[1].addr, 32'h400);
        chk("slow_stable", unstable, 0);
        chk("slow_ready_low", ready_viol, 0);
        // reset while allocating
        delay = 3;
        auto_mem = 0;
        issue(0, 32'h600, 0, 0);
        wait_req();
        chk("alloc_we", mem_we, 0);
        reset = 1;
        step();
        chk("rst_abort_req", mem_req, 0);
        chk("rst_abort_ready", is_ready, 1);
        reset = 0;
        sb.delete();
        out_before = out_count;
        ack_req++;
        step(); step(); step();
        chk("late_ack_no_output", out_count, out_before);
        chk("late_ack_req", mem_req, 0);
        chk("late_ack_ready", is_ready, 1);
        chk("rst_abort_hits", hit_count, 0);
        chk("rst_abort_misses", miss_count, 0);
        auto_mem = 1;
        access(0, 32'h600, 0, 0);
        // counter saturation
        force dut.hit_count = 32'hFFFF_FFFE;
        step();
        release dut.hit_count;
        step();
        chk("sat_preset", hit_count, 32'hFFFF_FFFE);
        access(0, 32'h600, 0, 1);
        access(0, 32'h604, 0, 1);
        access(0, 32'h608, 0, 1);
        step();
        chk("sat_hold", hit_count, 32'hFFFF_FFFF);
        // written-back data survives in memory
        access(0, 32'h100, 0, 0);
        repeat (3) step();
        chk("sb_drained", sb.size(), 0);
        chk("end_stable", unstable, 0);
        chk("end_ready_low", ready_viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
